control_unit_multicycle: RTL
============================

# control_unit_multicycle

Multicycle successor to the single-cycle control unit: a Moore FSM that sequences each RV32I instruction (lw, sw, R-type, I-type ALU, beq, jal) over 3–5 cycles on a shared instruction/data memory. It drives the datapath enables and mux selects and decodes ALUControl/ImmSrc from the instruction fields. It adds two things the single-cycle unit lacks: a memory request/ready handshake with wait states, and a retired-instruction counter. It sits between the instruction register and the multicycle datapath.

## Interface
- MEM_HANDSHAKE, 1, 1: memory accesses wait for mem_ready; 0: mem_ready ignored, treated as 1
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Op  in  7  instr[6:0]; funct3  in  3  instr[14:12]; funct7  in  7  instr[31:25]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables/select
- ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  mux selects / immediate format
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse on unsupported opcode
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired_cnt  out  CNT_W  retired instruction count
- state_o  out  4  current state (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Unused encodings go to FETCH.
- Transitions: FETCH→DECODE on rdy. DECODE→MEMADR (lw 0000011, sw 0100011), EXECUTER (0110011), EXECUTEI (0010011), BEQ (1100011), JAL (1101111). Any other opcode→FETCH with illegal_instr=1.
- MEMADR→MEMREAD (lw) / MEMWRITE (sw). MEMREAD→MEMWB on rdy. MEMWB→FETCH. MEMWRITE→FETCH on rdy. EXECUTER/EXECUTEI/JAL→ALUWB→FETCH. BEQ→FETCH.
- rdy = mem_ready if MEM_HANDSHAKE=1, else 1. FETCH, MEMREAD and MEMWRITE hold state while !rdy.
- Per-state outputs; any output not listed is 0:
  - FETCH: mem_req=1, IRWrite=rdy, ALUSrcB=10, ResultSrc=10, PCWrite=rdy
  - DECODE: ALUSrcA=01, ALUSrcB=01
  - MEMADR: ALUSrcA=10, ALUSrcB=01
  - MEMREAD: mem_req=1, AdrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=rdy
  - EXECUTER: ALUSrcA=10, ALUOp=10
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - ALUWB: RegWrite=1
  - BEQ: ALUSrcA=10, ALUOp=01, PCWrite=Zero
  - JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1
- ImmSrc from Op in every state: I-type/lw 00, sw 01, beq 10, jal 11, others 00.
- ALUControl derived from the internal ALUOp:
  - ALUOp 00→add; 01→sub
  - ALUOp 10 by funct3: 000→sub if Op[5]&funct7[5], else add; 010→slt; 110→or; 111→and; other→add
- instr_done=1 in MEMWB, ALUWB, BEQ, and in MEMWRITE when rdy. retired_cnt increments by 1 on each instr_done and wraps modulo 2^CNT_W.

## Timing
- State register and retired_cnt update on rising clk. All other outputs are combinational from state, Op/funct fields, Zero and mem_ready.
- Reset: rst high at an edge sets state=FETCH and retired_cnt=0.
- While rst is high, all outputs are forced to 0, including mem_req and state_o. Reset mid-instruction aborts the instruction with no write enables asserted in the rst cycle; fetch restarts on the first cycle after rst falls.
- Zero-wait latencies: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2 cycles. Each wait cycle adds 1.
- mem_req stays high continuously through wait states. IRWrite, PCWrite and MemWrite assert only in the rdy cycle, exactly once per access.
- Simultaneous instr_done and counter wrap: the counter rolls from all-ones to 0, and the pulse is still emitted.

## Test plan
- Reset: rst held 3 cycles mid-EXECUTER → all outputs 0 during rst; state_o=0 and retired_cnt=0 on release; FETCH with mem_req=1 next cycle.
- add x3,x1,x2 (Op 0110011, f3 000, f7 0), mem_ready=1 → states 0,1,6,8; ALUControl 000 in EXECUTER; RegWrite only in ALUWB; retired_cnt 0→1.
- sub then beq (Zero=1, then Zero=0) → sub gives ALUControl 001. beq taken: PCWrite=1 in BEQ. beq not taken: PCWrite=0. Both beq cases take 3 cycles.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD → lw total 10 cycles; IRWrite/PCWrite single pulse; RegWrite once in MEMWB.
- sw, MEM_HANDSHAKE=0 with mem_ready tied 0 → 4 cycles; MemWrite=1 for exactly one cycle; ImmSrc=01.
- Op 1111111 → illegal_instr pulse in DECODE, no RegWrite/MemWrite, return to FETCH, retired_cnt unchanged. CNT_W=4 after 16 retirements → retired_cnt=0.

Source files
------------

// File: rtl/control_unit_multicycle_if.sv
// Control-unit <-> datapath/memory bundle: instruction fields and status in, enables/selects out.
// master = control unit side, slave = datapath/memory side.
interface control_unit_multicycle_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             Zero;
    logic             mem_ready;

    logic             mem_req;
    logic             PCWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ImmSrc;
    logic [2:0]       ALUControl;
    logic             illegal_instr;
    logic             instr_done;
    logic [CNT_W-1:0] retired_cnt;
    logic [3:0]       state_o;

    modport master (
        input  Op, funct3, funct7, Zero, mem_ready,
        output mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               illegal_instr, instr_done, retired_cnt, state_o
    );

    modport slave (
        output Op, funct3, funct7, Zero, mem_ready,
        input  mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               illegal_instr, instr_done, retired_cnt, state_o
    );
endinterface

// File: rtl/control_unit_multicycle.sv
// Multicycle RV32I control unit: Moore FSM sequencing lw/sw/R/I/beq/jal over a shared memory
// with a request/ready handshake, plus a retired-instruction counter.
module control_unit_multicycle #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    control_unit_multicycle_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
        logic       done;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t           state;
    state_t           state_next;
    ctrl_t            ctrl;
    ctrl_t            ctrl_o;
    logic             rdy;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       alu_control;
    logic [1:0]       imm_src;
    logic             unused_funct7;

    assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (ctrl.done) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first keep this block free of inferred latches.
        state_next = FETCH;
        ctrl       = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.ir_write   = rdy;
                ctrl.pc_write   = rdy;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                state_next      = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                case (bus.Op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default: begin
                        state_next   = FETCH;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                state_next     = (bus.Op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                state_next   = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                ctrl.done       = 1'b1;
            end
            MEMWRITE: begin
                // Store retires in the same cycle memory accepts the write.
                ctrl.mem_req   = 1'b1;
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = rdy;
                ctrl.done      = rdy;
                state_next     = rdy ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = 2'b10;
                state_next     = ALUWB;
            end
            EXECUTEI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = 2'b10;
                state_next     = ALUWB;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            BEQ: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = 2'b01;
                ctrl.pc_write  = bus.Zero;
                ctrl.done      = 1'b1;
            end
            JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_write  = 1'b1;
                state_next     = ALUWB;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (ctrl.alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    // Only R-type (Op[5]=1) honours funct7[5] as subtract.
                    3'b000:  alu_control = (bus.Op[5] && bus.funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (bus.Op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Everything visible is held at zero while rst is high.
    assign ctrl_o = rst ? '0 : ctrl;

    assign bus.mem_req       = ctrl_o.mem_req;
    assign bus.PCWrite       = ctrl_o.pc_write;
    assign bus.AdrSrc        = ctrl_o.adr_src;
    assign bus.IRWrite       = ctrl_o.ir_write;
    assign bus.MemWrite      = ctrl_o.mem_write;
    assign bus.RegWrite      = ctrl_o.reg_write;
    assign bus.ResultSrc     = ctrl_o.result_src;
    assign bus.ALUSrcA       = ctrl_o.alu_src_a;
    assign bus.ALUSrcB       = ctrl_o.alu_src_b;
    assign bus.illegal_instr = ctrl_o.illegal;
    assign bus.instr_done    = ctrl_o.done;
    assign bus.ImmSrc        = rst ? 2'b00 : imm_src;
    assign bus.ALUControl    = rst ? 3'b000 : alu_control;
    assign bus.retired_cnt   = rst ? '0 : cnt;
    assign bus.state_o       = rst ? 4'd0 : state;
endmodule
